// File: rtl/clk_div_pkg.sv
// Shared types and constants for the integer clock divider.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } clk_div_state_t;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_bypass_mux.sv
// 2:1 clock select between the reference and the divided clock.
module clk_bypass_mux (
  input  logic sel,
  input  logic in0,
  input  logic in1,
  output logic out
);

  // Isolated so synthesis can map it onto a library clock-mux cell.
  assign out = sel ? in1 : in0;

endmodule

// File: rtl/clk_div_param.sv
// Runtime-ratio integer clock divider with period tick and
// reference bypass when disabled or ratio below two.
module clk_div_param
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLK_Ref,
  input  logic                 Reset,
  input  logic                 CLK_EN,
  input  logic [DIV_WIDTH-1:0] Div,
  output logic                 CLK_div_out,
  output logic                 Div_tick,
  output logic [DIV_WIDTH-1:0] Active_Div
);

  localparam logic [DIV_WIDTH:0] ONE = 1;
  localparam logic [DIV_WIDTH-1:0] MIN_N =
    DIV_WIDTH'(DIV_MIN);

  clk_div_state_t state;
  clk_div_state_t state_d;

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_d;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 clk_q;
  logic                 clk_d;
  logic                 tick_q;
  logic                 tick_d;

  logic [DIV_WIDTH:0] h_q;
  logic [DIV_WIDTH:0] cnt_inc;
  logic               div_ok;
  logic               at_end;
  logic               run_sel;

  // Extra bit keeps (N+1)/2 exact when N is all ones.
  assign h_q     = ({1'b0, div_q} + ONE) >> 1;
  assign cnt_inc = {1'b0, cnt} + ONE;
  assign div_ok  = (Div >= MIN_N);
  assign at_end  = (cnt == div_q - DIV_WIDTH'(1));

  always_ff @(posedge CLK_Ref or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (CLK_EN && div_ok) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!CLK_EN) begin
          state_d = IDLE;
        end else if (at_end && !div_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt;
    clk_d  = clk_q;
    tick_d = 1'b0;
    unique case (state)
      IDLE: begin
        div_d = Div;
        cnt_d = '0;
        clk_d = 1'b0;
        if (CLK_EN && div_ok) begin
          clk_d  = 1'b1;
          tick_d = 1'b1;
        end
      end
      RUN: begin
        if (!CLK_EN) begin
          div_d = Div;
          cnt_d = '0;
          clk_d = 1'b0;
        end else if (at_end) begin
          // New ratio is only picked up on a period boundary.
          div_d  = Div;
          cnt_d  = '0;
          clk_d  = div_ok;
          tick_d = div_ok;
        end else begin
          cnt_d = cnt_inc[DIV_WIDTH-1:0];
          clk_d = (cnt_inc < h_q);
        end
      end
      default: begin
        cnt_d = '0;
        clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_Ref or posedge Reset) begin
    if (Reset) begin
      div_q  <= '0;
      cnt    <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt    <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign run_sel    = (state == RUN);
  assign Div_tick   = tick_q;
  assign Active_Div = div_q;

  clk_bypass_mux u_mux (
    .sel (run_sel),
    .in0 (CLK_Ref),
    .in1 (clk_q),
    .out (CLK_div_out)
  );

endmodule

// File: tb/tb_clk_div_param.sv
// Directed bench for clk_div_param: ratio table plus
// hand-written ratio-change, enable and reset sequences.
module tb_clk_div_param;

  logic       CLK_Ref;
  logic       Reset;
  logic       CLK_EN;
  logic [7:0] Div;
  logic       CLK_div_out;
  logic       Div_tick;
  logic [7:0] Active_Div;

  int checks;
  int errors;

  clk_div_param #(.DIV_WIDTH(8)) dut (
    .CLK_Ref     (CLK_Ref),
    .Reset       (Reset),
    .CLK_EN      (CLK_EN),
    .Div         (Div),
    .CLK_div_out (CLK_div_out),
    .Div_tick    (Div_tick),
    .Active_Div  (Active_Div)
  );

  initial CLK_Ref = 1'b0;
  always #5 CLK_Ref = ~CLK_Ref;

  typedef struct {
    logic       en;
    logic [7:0] div;
    bit         bypass;
    int         high;
    int         low;
  } vec_t;

  vec_t tv[10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_Ref);
    #1;
  endtask

  // Reset asserted while CLK_Ref is low; outputs are checked in reset.
  task automatic apply_reset(input logic en,
                             input logic [7:0] div);
    @(negedge CLK_Ref);
    Reset  = 1'b1;
    CLK_EN = en;
    Div    = div;
    #1;
    check("rst_out_lo", 32'(CLK_div_out), 32'd0);
    check("rst_tick", 32'(Div_tick), 32'd0);
    check("rst_active", 32'(Active_Div), 32'd0);
    step();
    check("rst_out_hi", 32'(CLK_div_out), 32'd1);
    check("rst_active2", 32'(Active_Div), 32'd0);
    @(negedge CLK_Ref);
    Reset = 1'b0;
  endtask

  task automatic run_period(input string tag,
                            input int n,
                            input int h,
                            input logic [7:0] act);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_out"}, 32'(CLK_div_out),
            32'(i < h));
      check({tag, "_tick"}, 32'(Div_tick),
            32'(i == 0));
      check({tag, "_act"}, 32'(Active_Div), 32'(act));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    CLK_EN = 1'b0;
    Div    = 8'd0;

    tv[0] = '{1'b1, 8'd4,   1'b0, 2,   2};
    tv[1] = '{1'b1, 8'd5,   1'b0, 3,   2};
    tv[2] = '{1'b1, 8'd3,   1'b0, 2,   1};
    tv[3] = '{1'b1, 8'd2,   1'b0, 1,   1};
    tv[4] = '{1'b1, 8'd6,   1'b0, 3,   3};
    tv[5] = '{1'b1, 8'd7,   1'b0, 4,   3};
    tv[6] = '{1'b1, 8'd255, 1'b0, 128, 127};
    tv[7] = '{1'b1, 8'd0,   1'b1, 0,   0};
    tv[8] = '{1'b1, 8'd1,   1'b1, 0,   0};
    tv[9] = '{1'b0, 8'd4,   1'b1, 0,   0};

    #12;
    for (int v = 0; v < 10; v++) begin
      apply_reset(tv[v].en, tv[v].div);
      if (tv[v].bypass) begin
        for (int i = 0; i < 6; i++) begin
          step();
          check("byp_hi", 32'(CLK_div_out), 32'd1);
          check("byp_tick", 32'(Div_tick), 32'd0);
          check("byp_act", 32'(Active_Div),
                32'(tv[v].div));
          @(negedge CLK_Ref);
          #1;
          check("byp_lo", 32'(CLK_div_out), 32'd0);
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          run_period("tbl", tv[v].high + tv[v].low,
                     tv[v].high, tv[v].div);
        end
      end
    end

    // Ratio 4 -> 6 requested mid-period.
    apply_reset(1'b1, 8'd4);
    step();
    step();
    Div = 8'd6;
    step();
    check("chg_out2", 32'(CLK_div_out), 32'd0);
    check("chg_act2", 32'(Active_Div), 32'd4);
    step();
    check("chg_out3", 32'(CLK_div_out), 32'd0);
    check("chg_act3", 32'(Active_Div), 32'd4);
    run_period("chg6", 6, 3, 8'd6);
    run_period("chg6b", 6, 3, 8'd6);

    // Enable from bypass with ratio 2.
    apply_reset(1'b0, 8'd2);
    step();
    check("en2_byp", 32'(CLK_div_out), 32'd1);
    CLK_EN = 1'b1;
    step();
    check("en2_first", 32'(CLK_div_out), 32'd1);
    check("en2_tick", 32'(Div_tick), 32'd1);
    @(negedge CLK_Ref);
    #1;
    check("en2_neg", 32'(CLK_div_out), 32'd1);
    step();
    check("en2_low", 32'(CLK_div_out), 32'd0);
    run_period("en2", 2, 1, 8'd2);

    // Enable dropped during the high phase, then restored.
    apply_reset(1'b1, 8'd6);
    step();
    step();
    check("dis_cnt1", 32'(CLK_div_out), 32'd1);
    CLK_EN = 1'b0;
    step();
    check("dis_hi", 32'(CLK_div_out), 32'd1);
    check("dis_tick", 32'(Div_tick), 32'd0);
    check("dis_act", 32'(Active_Div), 32'd6);
    @(negedge CLK_Ref);
    #1;
    check("dis_lo", 32'(CLK_div_out), 32'd0);
    CLK_EN = 1'b1;
    run_period("reen", 6, 3, 8'd6);

    // Asynchronous reset in the low phase of a run.
    apply_reset(1'b1, 8'd5);
    for (int i = 0; i < 4; i++) step();
    check("ar_pre_out", 32'(CLK_div_out), 32'd0);
    check("ar_pre_act", 32'(Active_Div), 32'd5);
    #1;
    Reset = 1'b1;
    #1;
    check("ar_out", 32'(CLK_div_out), 32'd1);
    check("ar_act", 32'(Active_Div), 32'd0);
    check("ar_tick", 32'(Div_tick), 32'd0);
    @(negedge CLK_Ref);
    #1;
    check("ar_out_lo", 32'(CLK_div_out), 32'd0);
    Reset = 1'b0;
    run_period("ar_resume", 5, 3, 8'd5);
    run_period("ar_resume2", 5, 3, 8'd5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
